// File: rtl/rf_delay_calibrator.sv
// rf_delay_calibrator
// Calibrates the RF matched-delay line. For each of the four delay taps it
// launches SAMPLES four-phase test pulses. It times the synchronised return
// edge and keeps the worst-case latency per tap. It then picks the shortest
// tap whose worst case reaches target_cycles. The chosen tap stays on
// delay_select until the next accepted start or reset.
module rf_delay_calibrator #(
    parameter int CW      = 8,
    parameter int SAMPLES = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] target_cycles,
    output logic          cal_req,
    input  logic          cal_ack,
    output logic [1:0]    delay_select,
    output logic          busy,
    output logic          cal_valid,
    output logic          short_flag,
    output logic          error,
    output logic [CW-1:0] meas_lat
);

    localparam int            SW        = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam logic [SW-1:0] SMP_LAST  = SW'(SAMPLES - 1);
    localparam logic [CW-1:0] TMO       = CW'(TIMEOUT);
    localparam logic [1:0]    SEL_LAST  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RISE,
        FALL,
        NEXT,
        DECIDE,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic          ack_meta_q, ack_s_q;
    logic [CW-1:0] target_q, target_d;
    logic [1:0]    sel_q, sel_d;
    logic [SW-1:0] smp_q, smp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] max_q [4];
    logic [CW-1:0] max_d [4];
    logic          cal_req_q, cal_req_d;
    logic [1:0]    dsel_q, dsel_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          short_q, short_d;
    logic          error_q, error_d;
    logic [CW-1:0] lat_q, lat_d;

    logic [CW-1:0] cnt_inc;
    logic [1:0]    pick;
    logic          pick_ok;

    // Two-flop synchroniser: ack_s_q is the only view of cal_ack the FSM uses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values; blocking here would collapse the two stages.
            ack_meta_q <= cal_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Latency counter increment, saturating at all-ones.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Selection: smallest tap whose worst-case latency meets the target, else tap 3.
    always_comb begin
        pick    = SEL_LAST;
        pick_ok = 1'b0;
        for (int s = 3; s >= 0; s--) begin
            if (max_q[s] >= target_q) begin
                pick    = 2'(s);
                pick_ok = 1'b1;
            end
        end
    end

    // Next-state and next-output logic for the calibration sequencer.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        target_d  = target_q;
        sel_d     = sel_q;
        smp_d     = smp_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        cal_req_d = cal_req_q;
        dsel_d    = dsel_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        short_d   = short_q;
        error_d   = error_q;
        lat_d     = lat_q;

        unique case (state_q)
            // DONE behaves like IDLE for start, so results hold until a new run is accepted.
            IDLE, DONE: begin
                if (start) begin
                    target_d = target_cycles;
                    sel_d    = 2'd0;
                    smp_d    = '0;
                    cnt_d    = '0;
                    for (int s = 0; s < 4; s++) max_d[s] = '0;
                    valid_d  = 1'b0;
                    short_d  = 1'b0;
                    error_d  = 1'b0;
                    busy_d   = 1'b1;
                    dsel_d   = 2'd0;
                    state_d  = SETUP;
                end
            end

            // The tap was driven on entry; this cycle lets it settle before the pulse.
            SETUP: begin
                cal_req_d = 1'b1;
                cnt_d     = '0;
                state_d   = RISE;
            end

            // cnt_q equals the number of edges since the launch edge, up to and
            // including the edge at which ack_s_q captured 1.
            RISE: begin
                if (ack_s_q) begin
                    if (cnt_q > max_q[sel_q]) max_d[sel_q] = cnt_q;
                    cal_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = FALL;
                end else if (cnt_q >= TMO) begin
                    cal_req_d = 1'b0;
                    dsel_d    = SEL_LAST;
                    lat_d     = '0;
                    error_d   = 1'b1;
                    valid_d   = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // Return-to-zero phase; the next pulse only starts once ack is low again.
            FALL: begin
                if (!ack_s_q) begin
                    if (smp_q == SMP_LAST) begin
                        state_d = NEXT;
                    end else begin
                        smp_d   = smp_q + 1'b1;
                        state_d = SETUP;
                    end
                end else if (cnt_q >= TMO) begin
                    dsel_d  = SEL_LAST;
                    lat_d   = '0;
                    error_d = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // Advance to the next tap, or finish the sweep.
            NEXT: begin
                smp_d = '0;
                if (sel_q != SEL_LAST) begin
                    sel_d   = sel_q + 1'b1;
                    dsel_d  = sel_q + 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = DECIDE;
                end
            end

            // Publish the chosen tap and its worst-case latency.
            DECIDE: begin
                dsel_d  = pick;
                lat_d   = max_q[pick];
                short_d = !pick_ok;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any run and discards partial results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            sel_q     <= 2'd0;
            smp_q     <= '0;
            cnt_q     <= '0;
            // NOTE: the max table is four plain registers, not a RAM, so it takes
            // the async reset like any other state.
            for (int s = 0; s < 4; s++) max_q[s] <= '0;
            cal_req_q <= 1'b0;
            dsel_q    <= SEL_LAST;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            short_q   <= 1'b0;
            error_q   <= 1'b0;
            lat_q     <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            sel_q     <= sel_d;
            smp_q     <= smp_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            cal_req_q <= cal_req_d;
            dsel_q    <= dsel_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            short_q   <= short_d;
            error_q   <= error_d;
            lat_q     <= lat_d;
        end
    end

    assign cal_req      = cal_req_q;
    assign delay_select = dsel_q;
    assign busy         = busy_q;
    assign cal_valid    = valid_q;
    assign short_flag   = short_q;
    assign error        = error_q;
    assign meas_lat     = lat_q;

endmodule
